// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - funct3 codes, FSM state encoding and lane helpers for lsu_mem_bridge
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;
  localparam int WORD_W = 32;

  // Access size lives in funct3[1:0] for both loads and stores.
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LD     = 3'd1,
    WR     = 3'd2,
    RMW_RD = 3'd3,
    RMW_WR = 3'd4,
    ERR    = 3'd5,
    RESP   = 3'd6
  } state_e;

  function automatic logic f3_illegal(input logic [2:0] f3);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
    return ((f3[1:0] == SZ_H) && lo[0]) || ((f3[1:0] == SZ_W) && (lo != 2'b00));
  endfunction

  function automatic logic [1:0] align_lo(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      SZ_H:    return {lo[1], 1'b0};
      SZ_W:    return 2'b00;
      default: return lo;
    endcase
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// rtl/lsu_byte_lane.sv - combinational lane select/extension for loads and lane merge for sub-word stores
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [2:0]        funct3_i,
  input  logic [1:0]        addr_lo_i,
  input  logic [WORD_W-1:0] rword_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] load_data_o,
  output logic [WORD_W-1:0] merged_o
);

  logic [BYTE_W-1:0] byte_sel;
  logic [HALF_W-1:0] half_sel;

  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_sel = rword_i[7:0];
      2'd1:    byte_sel = rword_i[15:8];
      2'd2:    byte_sel = rword_i[23:16];
      default: byte_sel = rword_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];
  end

  always_comb begin
    case (funct3_i)
      F3_B:    load_data_o = {{(WORD_W-BYTE_W){byte_sel[BYTE_W-1]}}, byte_sel};
      F3_H:    load_data_o = {{(WORD_W-HALF_W){half_sel[HALF_W-1]}}, half_sel};
      F3_BU:   load_data_o = {{(WORD_W-BYTE_W){1'b0}}, byte_sel};
      F3_HU:   load_data_o = {{(WORD_W-HALF_W){1'b0}}, half_sel};
      default: load_data_o = rword_i;
    endcase
  end

  // Only the addressed lanes take store data; the rest keep the word just read.
  always_comb begin
    merged_o = rword_i;
    case (funct3_i[1:0])
      SZ_B: begin
        case (addr_lo_i)
          2'd0:    merged_o[7:0]   = wdata_i[7:0];
          2'd1:    merged_o[15:8]  = wdata_i[7:0];
          2'd2:    merged_o[23:16] = wdata_i[7:0];
          default: merged_o[31:24] = wdata_i[7:0];
        endcase
      end
      SZ_H: begin
        if (addr_lo_i[1]) merged_o[31:16] = wdata_i[15:0];
        else              merged_o[15:0]  = wdata_i[15:0];
      end
      default: merged_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_mem_bridge.sv
// rtl/lsu_mem_bridge.sv - RISC-V load/store to word-memory bridge; LSU_MISALIGN_TRAP_EN selects trapping of illegal accesses
module lsu_mem_bridge
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [2:0]            req_funct3_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  mem_read_o,
  output logic                  mem_write_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [2:0]            f3_q, f3_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] merged_q, merged_d;
`ifdef LSU_MISALIGN_TRAP_EN
  logic                  err_q, err_d;
`endif

  logic [2:0]            eff_f3;
  logic [ADDR_WIDTH-1:0] eff_addr;
  logic [DATA_WIDTH-1:0] lane_load;
  logic [DATA_WIDTH-1:0] lane_merged;

  lsu_byte_lane u_lane (
    .funct3_i    (f3_q),
    .addr_lo_i   (addr_q[1:0]),
    .rword_i     (mem_rdata_i),
    .wdata_i     (wdata_q),
    .load_data_o (lane_load),
    .merged_o    (lane_merged)
  );

  // Without trapping, bad requests are coerced into a legal naturally aligned access.
  always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
    eff_f3   = req_funct3_i;
    eff_addr = req_addr_i;
`else
    eff_f3   = f3_illegal(req_funct3_i) ? F3_W : req_funct3_i;
    eff_addr = {req_addr_i[ADDR_WIDTH-1:2], align_lo(eff_f3, req_addr_i[1:0])};
`endif
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    f3_d     = f3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    merged_d = merged_q;
`ifdef LSU_MISALIGN_TRAP_EN
    err_d    = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          we_d    = req_we_i;
          f3_d    = eff_f3;
          addr_d  = eff_addr;
          wdata_d = req_wdata_i;
          rdata_d = '0;
          if (!req_we_i)                  state_d = LD;
          else if (eff_f3[1:0] == SZ_W)   state_d = WR;
          else                            state_d = RMW_RD;
`ifdef LSU_MISALIGN_TRAP_EN
          err_d = f3_illegal(req_funct3_i) || misaligned(req_funct3_i, req_addr_i[1:0]);
          if (err_d) state_d = ERR;
`endif
        end
      end
      LD: begin
        rdata_d = lane_load;
        state_d = RESP;
      end
      WR:     state_d = RESP;
      RMW_RD: begin
        merged_d = lane_merged;
        state_d  = RMW_WR;
      end
      RMW_WR: state_d = RESP;
`ifdef LSU_MISALIGN_TRAP_EN
      ERR:    state_d = RESP;
`endif
      RESP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      f3_q     <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      merged_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      f3_q     <= f3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      merged_q <= merged_d;
`ifdef LSU_MISALIGN_TRAP_EN
      err_q    <= err_d;
`endif
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign mem_read_o  = (state_q == LD) || (state_q == RMW_RD);
  assign mem_write_o = (state_q == WR) || (state_q == RMW_WR);
  assign mem_addr_o  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_rdata_o = (rsp_valid_o && !we_q) ? rdata_q : '0;

  always_comb begin
    case (state_q)
      WR:      mem_wdata_o = wdata_q;
      RMW_WR:  mem_wdata_o = merged_q;
      default: mem_wdata_o = '0;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign rsp_err_o = rsp_valid_o & err_q;
`else
  assign rsp_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_mem_bridge.sv
// tb/tb_lsu_mem_bridge.sv - scoreboard bench for lsu_mem_bridge with a word-memory model
module tb_lsu_mem_bridge;
  import lsu_pkg::*;

  logic        clk;
  logic        reset;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [2:0]  req_funct3_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        mem_read_o;
  logic        mem_write_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  int          n_pass  = 0;
  int          n_total = 0;

  logic [31:0] mem [0:63];
  int          wr_count = 0;
  logic        pl_en;
  logic [5:0]  pl_idx;
  logic [31:0] pl_val;

  lsu_mem_bridge #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_we_i     (req_we_i),
    .req_funct3_i (req_funct3_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_rdata_o  (rsp_rdata_o),
    .rsp_err_o    (rsp_err_o),
    .mem_read_o   (mem_read_o),
    .mem_write_o  (mem_write_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (mem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata_i = mem_read_o ? mem[mem_addr_o[7:2]] : 32'h0;

  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_val;
    if (mem_write_o) begin
      mem[mem_addr_o[7:2]] <= mem_wdata_o;
      wr_count <= wr_count + 1;
    end
  end

  task automatic preload(input logic [5:0] idx, input logic [31:0] val);
    pl_en = 1'b1; pl_idx = idx; pl_val = val;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Drives one request from IDLE and measures the response; returns at posedge+1 back in IDLE.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output int lat, output logic [31:0] rd,
                       output logic er, output int nwr, output logic [31:0] lastw,
                       output logic pulse_ok);
    lat = 0; nwr = 0; lastw = '0; rd = '0; er = 1'b0; pulse_ok = 1'b0;
    req_valid_i = 1'b1; req_we_i = we; req_funct3_i = f3; req_addr_i = addr; req_wdata_i = wdata;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      if (mem_write_o) begin nwr++; lastw = mem_wdata_o; end
      if (rsp_valid_o) begin rd = rsp_rdata_o; er = rsp_err_o; break; end
    end
    @(posedge clk); #1;
    pulse_ok = !rsp_valid_o;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_total++; if (req_ready_o !== 1'b1) $display("FAIL reset_ready: got %b want 1", req_ready_o); else n_pass++;
    n_total++; if (rsp_valid_o !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid_o); else n_pass++;
    n_total++; if ({mem_read_o, mem_write_o} !== 2'b00) $display("FAIL reset_strobes: got %b want 00", {mem_read_o, mem_write_o}); else n_pass++;
    n_total++; if (mem_addr_o !== 32'h0) $display("FAIL reset_mem_addr: got %h want 0", mem_addr_o); else n_pass++;
    n_total++; if ({rsp_rdata_o, mem_wdata_o, rsp_err_o} !== 65'h0) $display("FAIL reset_data: got %h/%h/%b want 0", rsp_rdata_o, mem_wdata_o, rsp_err_o); else n_pass++;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_loads();
    logic [2:0]  t_f3   [7] = '{F3_B, F3_BU, F3_H, F3_HU, F3_W, F3_B, F3_BU};
    logic [31:0] t_addr [7] = '{32'h11, 32'h11, 32'h12, 32'h12, 32'h10, 32'h13, 32'h10};
    logic [31:0] t_exp  [7] = '{32'hFFFFFFAA, 32'h000000AA, 32'hFFFF8899, 32'h00008899,
                                32'h8899AABB, 32'hFFFFFF88, 32'h000000BB};
    int lat, nwr; logic [31:0] rd, lastw; logic er, pulse; exp_t e;
    preload(6'd4, 32'h8899AABB);
    for (int i = 0; i < 7; i++) begin
      sb_q.push_back('{rdata: t_exp[i], err: 1'b0});
      issue(1'b0, t_f3[i], t_addr[i], 32'h0, lat, rd, er, nwr, lastw, pulse);
      e = sb_q.pop_front();
      n_total++; if (rd !== e.rdata) $display("FAIL load_rdata[%0d]: got %h want %h", i, rd, e.rdata); else n_pass++;
      n_total++; if (er !== e.err) $display("FAIL load_err[%0d]: got %b want %b", i, er, e.err); else n_pass++;
      n_total++; if (lat !== 2) $display("FAIL load_latency[%0d]: got %0d want 2", i, lat); else n_pass++;
      n_total++; if (pulse !== 1'b1) $display("FAIL load_single_pulse[%0d]: got %b want 1", i, pulse); else n_pass++;
      n_total++; if (nwr !== 0) $display("FAIL load_no_write[%0d]: got %0d want 0", i, nwr); else n_pass++;
    end
  endtask

  task automatic test_stores();
    logic        t_we    [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [2:0]  t_f3    [6] = '{F3_B, F3_W, F3_W, F3_H, F3_H, F3_BU};
    logic [31:0] t_addr  [6] = '{32'h12, 32'h10, 32'h14, 32'h16, 32'h16, 32'h17};
    logic [31:0] t_wd    [6] = '{32'h12345655, 32'h0, 32'hDEADBEEF, 32'h00007777, 32'h0, 32'h0};
    logic [31:0] t_rd    [6] = '{32'h0, 32'h8855AABB, 32'h0, 32'h0, 32'h00007777, 32'h00000077};
    int          t_lat   [6] = '{3, 2, 2, 3, 2, 2};
    int          t_nwr   [6] = '{1, 0, 1, 1, 0, 0};
    logic [31:0] t_lastw [6] = '{32'h8855AABB, 32'h0, 32'hDEADBEEF, 32'h7777BEEF, 32'h0, 32'h0};
    int lat, nwr; logic [31:0] rd, lastw; logic er, pulse; exp_t e;
    preload(6'd4, 32'h8899AABB);
    for (int i = 0; i < 6; i++) begin
      sb_q.push_back('{rdata: t_rd[i], err: 1'b0});
      issue(t_we[i], t_f3[i], t_addr[i], t_wd[i], lat, rd, er, nwr, lastw, pulse);
      e = sb_q.pop_front();
      n_total++; if (rd !== e.rdata) $display("FAIL store_rdata[%0d]: got %h want %h", i, rd, e.rdata); else n_pass++;
      n_total++; if (er !== e.err) $display("FAIL store_err[%0d]: got %b want %b", i, er, e.err); else n_pass++;
      n_total++; if (lat !== t_lat[i]) $display("FAIL store_latency[%0d]: got %0d want %0d", i, lat, t_lat[i]); else n_pass++;
      n_total++; if (pulse !== 1'b1) $display("FAIL store_single_pulse[%0d]: got %b want 1", i, pulse); else n_pass++;
      n_total++; if (nwr !== t_nwr[i]) $display("FAIL store_write_count[%0d]: got %0d want %0d", i, nwr, t_nwr[i]); else n_pass++;
      if (t_nwr[i] == 1) begin
        n_total++; if (lastw !== t_lastw[i]) $display("FAIL store_wdata[%0d]: got %h want %h", i, lastw, t_lastw[i]); else n_pass++;
      end
    end
  endtask

  task automatic test_misalign();
    logic        t_we    [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [2:0]  t_f3    [4] = '{F3_W, F3_W, 3'b011, F3_H};
    logic [31:0] t_addr  [4] = '{32'h13, 32'h10, 32'h10, 32'h11};
`ifdef LSU_MISALIGN_TRAP_EN
    logic [31:0] t_rd    [4] = '{32'h0, 32'h8855AABB, 32'h0, 32'h0};
    logic        t_err   [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    int          t_nwr   [4] = '{0, 0, 0, 0};
`else
    logic [31:0] t_rd    [4] = '{32'h0, 32'h11223344, 32'h11223344, 32'h00003344};
    logic        t_err   [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
    int          t_nwr   [4] = '{1, 0, 0, 0};
`endif
    int lat, nwr; logic [31:0] rd, lastw; logic er, pulse; exp_t e;
    preload(6'd4, 32'h8855AABB);
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back('{rdata: t_rd[i], err: t_err[i]});
      issue(t_we[i], t_f3[i], t_addr[i], (i == 0) ? 32'h11223344 : 32'h0, lat, rd, er, nwr, lastw, pulse);
      e = sb_q.pop_front();
      n_total++; if (rd !== e.rdata) $display("FAIL misalign_rdata[%0d]: got %h want %h", i, rd, e.rdata); else n_pass++;
      n_total++; if (er !== e.err) $display("FAIL misalign_err[%0d]: got %b want %b", i, er, e.err); else n_pass++;
      n_total++; if (lat !== 2) $display("FAIL misalign_latency[%0d]: got %0d want 2", i, lat); else n_pass++;
      n_total++; if (nwr !== t_nwr[i]) $display("FAIL misalign_write_count[%0d]: got %0d want %0d", i, nwr, t_nwr[i]); else n_pass++;
      if (t_nwr[i] == 1) begin
        n_total++; if (lastw !== 32'h11223344) $display("FAIL misalign_wdata[%0d]: got %h want 11223344", i, lastw); else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    int low = 0, nrsp = 0, wc0; logic dropped = 1'b0; exp_t e;
    preload(6'd6, 32'h0);
    wc0 = wr_count;
    sb_q.push_back('{rdata: 32'h0, err: 1'b0});
    sb_q.push_back('{rdata: 32'h55550000, err: 1'b0});
    req_valid_i = 1'b1; req_we_i = 1'b1; req_funct3_i = F3_H; req_addr_i = 32'h1A; req_wdata_i = 32'hAAAA5555;
    @(posedge clk); #1;
    req_we_i = 1'b0; req_funct3_i = F3_W; req_addr_i = 32'h18; req_wdata_i = 32'h0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rsp_valid_o) begin
        nrsp++;
        n_total++;
        if (sb_q.size() == 0) $display("FAIL b2b_extra_rsp: got rdata %h want no response", rsp_rdata_o);
        else begin
          e = sb_q.pop_front();
          if (rsp_rdata_o !== e.rdata) $display("FAIL b2b_rdata[%0d]: got %h want %h", nrsp, rsp_rdata_o, e.rdata);
          else n_pass++;
        end
      end
      if (!dropped) begin
        if (!req_ready_o) low++;
        else if (low > 0) begin
          @(posedge clk); #1;
          req_valid_i = 1'b0;
          dropped = 1'b1;
        end
      end
    end
    req_valid_i = 1'b0;
    n_total++; if (low !== 3) $display("FAIL b2b_ready_low: got %0d want 3", low); else n_pass++;
    n_total++; if (nrsp !== 2) $display("FAIL b2b_rsp_count: got %0d want 2", nrsp); else n_pass++;
    n_total++; if (wr_count - wc0 !== 1) $display("FAIL b2b_write_count: got %0d want 1", wr_count - wc0); else n_pass++;
    sb_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int wc0, bad_rsp = 0, bad_wr = 0, lat, nwr; logic [31:0] rd, lastw; logic er, pulse; exp_t e;
    preload(6'd4, 32'hCAFEF00D);
    wc0 = wr_count;
    req_valid_i = 1'b1; req_we_i = 1'b1; req_funct3_i = F3_B; req_addr_i = 32'h11; req_wdata_i = 32'h000000FF;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    n_total++; if (mem_read_o !== 1'b1) $display("FAIL rst_mid_in_rmw_rd: got %b want 1", mem_read_o); else n_pass++;
    #2 reset = 1'b0;
    #1;
    n_total++; if (req_ready_o !== 1'b1) $display("FAIL rst_mid_ready: got %b want 1", req_ready_o); else n_pass++;
    n_total++; if ({mem_read_o, mem_write_o, rsp_valid_o} !== 3'b000) $display("FAIL rst_mid_strobes: got %b want 000", {mem_read_o, mem_write_o, rsp_valid_o}); else n_pass++;
    n_total++; if (mem_addr_o !== 32'h0) $display("FAIL rst_mid_addr: got %h want 0", mem_addr_o); else n_pass++;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    n_total++; if (req_ready_o !== 1'b1) $display("FAIL rst_mid_ready_after: got %b want 1", req_ready_o); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid_o) bad_rsp++;
      if (mem_write_o) bad_wr++;
      @(negedge clk);
    end
    n_total++; if (bad_rsp !== 0) $display("FAIL rst_mid_no_rsp: got %0d want 0", bad_rsp); else n_pass++;
    n_total++; if (bad_wr !== 0 || wr_count !== wc0) $display("FAIL rst_mid_no_write: got %0d want 0", wr_count - wc0); else n_pass++;
    @(posedge clk); #1;
    sb_q.push_back('{rdata: 32'hCAFEF00D, err: 1'b0});
    issue(1'b0, F3_W, 32'h10, 32'h0, lat, rd, er, nwr, lastw, pulse);
    e = sb_q.pop_front();
    n_total++; if (rd !== e.rdata) $display("FAIL rst_mid_mem_intact: got %h want %h", rd, e.rdata); else n_pass++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid_i = 1'b0; req_we_i = 1'b0; req_funct3_i = 3'b000;
    req_addr_i = 32'h0; req_wdata_i = 32'h0; pl_en = 1'b0; pl_idx = 6'd0; pl_val = 32'h0;
    test_reset();
    test_loads();
    test_stores();
    test_misalign();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
